// File: rtl/alu_rs_if.sv
// Bundles the dispatch, CDB snoop and issue buses of the ALU reservation station.
// The slave modport is the station itself; the master modport is its environment.
interface alu_rs_if #(
    parameter int ROB_IDX_W = 4,
    parameter int OPT_W     = 6
);
    logic                 dsp_valid;
    logic [OPT_W-1:0]     dsp_opt;
    logic [31:0]          dsp_val1;
    logic [31:0]          dsp_val2;
    logic [ROB_IDX_W-1:0] dsp_dep1;
    logic [ROB_IDX_W-1:0] dsp_dep2;
    logic [31:0]          dsp_imm;
    logic [ROB_IDX_W-1:0] dsp_rob_idx;
    logic                 rs_full;

    logic                 cdb_alu_valid;
    logic [ROB_IDX_W-1:0] cdb_alu_src;
    logic [31:0]          cdb_alu_val;
    logic                 cdb_lsb_valid;
    logic [ROB_IDX_W-1:0] cdb_lsb_src;
    logic [31:0]          cdb_lsb_val;

    logic                 rs_valid;
    logic [OPT_W-1:0]     rs_opt;
    logic [31:0]          rs_val1;
    logic [31:0]          rs_val2;
    logic [31:0]          rs_imm;
    logic [ROB_IDX_W-1:0] rs_rob_idx;

    modport master (
        output dsp_valid, dsp_opt, dsp_val1, dsp_val2, dsp_dep1, dsp_dep2, dsp_imm, dsp_rob_idx,
        output cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_lsb_valid, cdb_lsb_src, cdb_lsb_val,
        input  rs_full, rs_valid, rs_opt, rs_val1, rs_val2, rs_imm, rs_rob_idx
    );

    modport slave (
        input  dsp_valid, dsp_opt, dsp_val1, dsp_val2, dsp_dep1, dsp_dep2, dsp_imm, dsp_rob_idx,
        input  cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_lsb_valid, cdb_lsb_src, cdb_lsb_val,
        output rs_full, rs_valid, rs_opt, rs_val1, rs_val2, rs_imm, rs_rob_idx
    );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops both CDBs
// for pending operand tags and issues the lowest-index ready op once per cycle.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_IDX_W = 4,
    parameter int OPT_W     = 6
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    input  logic    flush,
    alu_rs_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] dep;
        logic [31:0]          val;
    } opnd_t;

    typedef struct packed {
        logic [OPT_W-1:0]     opt;
        opnd_t                src1;
        opnd_t                src2;
        logic [31:0]          imm;
        logic [ROB_IDX_W-1:0] robIdx;
    } entry_t;

    logic [RS_SIZE-1:0]   busy_q, busy_d;
    entry_t               entry_q [RS_SIZE];
    entry_t               entry_d [RS_SIZE];

    logic                 rsValid_q, rsValid_d;
    logic [OPT_W-1:0]     rsOpt_q, rsOpt_d;
    logic [31:0]          rsVal1_q, rsVal1_d;
    logic [31:0]          rsVal2_q, rsVal2_d;
    logic [31:0]          rsImm_q, rsImm_d;
    logic [ROB_IDX_W-1:0] rsRobIdx_q, rsRobIdx_d;

    logic                 freeFound, readyFound;
    logic [IDX_W-1:0]     freeIdx, readyIdx;

    // Tag 0 means "no dependency", so a waiting operand can never match it.
    function automatic opnd_t resolve(
        input opnd_t                o,
        input logic                 aluValid,
        input logic [ROB_IDX_W-1:0] aluSrc,
        input logic [31:0]          aluVal,
        input logic                 lsbValid,
        input logic [ROB_IDX_W-1:0] lsbSrc,
        input logic [31:0]          lsbVal
    );
        opnd_t r;
        r = o;
        if (o.dep != '0) begin
            if (aluValid && aluSrc == o.dep) begin
                r.dep = '0;
                r.val = aluVal;
            end else if (lsbValid && lsbSrc == o.dep) begin
                r.dep = '0;
                r.val = lsbVal;
            end
        end
        return r;
    endfunction

    always_comb begin
        busy_d     = busy_q;
        entry_d    = entry_q;
        rsValid_d  = rsValid_q;
        rsOpt_d    = rsOpt_q;
        rsVal1_d   = rsVal1_q;
        rsVal2_d   = rsVal2_q;
        rsImm_d    = rsImm_q;
        rsRobIdx_d = rsRobIdx_q;
        freeFound  = 1'b0;
        freeIdx    = '0;
        readyFound = 1'b0;
        readyIdx   = '0;

        // Both selections look only at registered state, so nothing issues on its dispatch edge.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy_q[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (busy_q[i] && entry_q[i].src1.dep == '0 && entry_q[i].src2.dep == '0 && !readyFound) begin
                readyFound = 1'b1;
                readyIdx   = IDX_W'(i);
            end
        end

        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    entry_d[i].src1 = resolve(entry_q[i].src1, bus.cdb_alu_valid, bus.cdb_alu_src,
                                              bus.cdb_alu_val, bus.cdb_lsb_valid, bus.cdb_lsb_src,
                                              bus.cdb_lsb_val);
                    entry_d[i].src2 = resolve(entry_q[i].src2, bus.cdb_alu_valid, bus.cdb_alu_src,
                                              bus.cdb_alu_val, bus.cdb_lsb_valid, bus.cdb_lsb_src,
                                              bus.cdb_lsb_val);
                end
            end

            rsValid_d  = readyFound;
            rsOpt_d    = '0;
            rsVal1_d   = '0;
            rsVal2_d   = '0;
            rsImm_d    = '0;
            rsRobIdx_d = '0;
            if (readyFound) begin
                busy_d[readyIdx] = 1'b0;
                rsOpt_d          = entry_q[readyIdx].opt;
                rsVal1_d         = entry_q[readyIdx].src1.val;
                rsVal2_d         = entry_q[readyIdx].src2.val;
                rsImm_d          = entry_q[readyIdx].imm;
                rsRobIdx_d       = entry_q[readyIdx].robIdx;
            end

            if (bus.dsp_valid && freeFound) begin
                busy_d[freeIdx]         = 1'b1;
                entry_d[freeIdx].opt    = bus.dsp_opt;
                entry_d[freeIdx].imm    = bus.dsp_imm;
                entry_d[freeIdx].robIdx = bus.dsp_rob_idx;
                entry_d[freeIdx].src1   = resolve('{dep: bus.dsp_dep1, val: bus.dsp_val1},
                                                  bus.cdb_alu_valid, bus.cdb_alu_src, bus.cdb_alu_val,
                                                  bus.cdb_lsb_valid, bus.cdb_lsb_src, bus.cdb_lsb_val);
                entry_d[freeIdx].src2   = resolve('{dep: bus.dsp_dep2, val: bus.dsp_val2},
                                                  bus.cdb_alu_valid, bus.cdb_alu_src, bus.cdb_alu_val,
                                                  bus.cdb_lsb_valid, bus.cdb_lsb_src, bus.cdb_lsb_val);
            end

            if (flush) begin
                busy_d     = '0;
                rsValid_d  = 1'b0;
                rsOpt_d    = '0;
                rsVal1_d   = '0;
                rsVal2_d   = '0;
                rsImm_d    = '0;
                rsRobIdx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            rsValid_q  <= 1'b0;
            rsOpt_q    <= '0;
            rsVal1_q   <= '0;
            rsVal2_q   <= '0;
            rsImm_q    <= '0;
            rsRobIdx_q <= '0;
        end else begin
            busy_q     <= busy_d;
            rsValid_q  <= rsValid_d;
            rsOpt_q    <= rsOpt_d;
            rsVal1_q   <= rsVal1_d;
            rsVal2_q   <= rsVal2_d;
            rsImm_q    <= rsImm_d;
            rsRobIdx_q <= rsRobIdx_d;
        end
    end

    // Payload of a free entry is meaningless, so it needs no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign bus.rs_full    = &busy_q;
    assign bus.rs_valid   = rsValid_q;
    assign bus.rs_opt     = rsOpt_q;
    assign bus.rs_val1    = rsVal1_q;
    assign bus.rs_val2    = rsVal2_q;
    assign bus.rs_imm     = rsImm_q;
    assign bus.rs_rob_idx = rsRobIdx_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed-vector bench for alu_rs: ready issue, wakeup, bypass, full, flush, freeze and async reset.
module tb_alu_rs;
    localparam int ROB_IDX_W = 4;
    localparam int OPT_W     = 6;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;
    int   vectorCount = 0;
    int   missCount   = 0;

    alu_rs_if #(.ROB_IDX_W(ROB_IDX_W), .OPT_W(OPT_W)) bus ();

    alu_rs #(.RS_SIZE(8), .ROB_IDX_W(ROB_IDX_W), .OPT_W(OPT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.dsp_valid     = 1'b0;
        bus.dsp_opt       = '0;
        bus.dsp_val1      = '0;
        bus.dsp_val2      = '0;
        bus.dsp_dep1      = '0;
        bus.dsp_dep2      = '0;
        bus.dsp_imm       = '0;
        bus.dsp_rob_idx   = '0;
        bus.cdb_alu_valid = 1'b0;
        bus.cdb_alu_src   = '0;
        bus.cdb_alu_val   = '0;
        bus.cdb_lsb_valid = 1'b0;
        bus.cdb_lsb_src   = '0;
        bus.cdb_lsb_val   = '0;
    endtask

    task automatic applyStimulus(input logic [OPT_W-1:0] opt, input logic [31:0] v1,
                                 input logic [ROB_IDX_W-1:0] d1, input logic [31:0] v2,
                                 input logic [ROB_IDX_W-1:0] d2, input logic [31:0] imm,
                                 input logic [ROB_IDX_W-1:0] rob);
        bus.dsp_valid   = 1'b1;
        bus.dsp_opt     = opt;
        bus.dsp_val1    = v1;
        bus.dsp_dep1    = d1;
        bus.dsp_val2    = v2;
        bus.dsp_dep2    = d2;
        bus.dsp_imm     = imm;
        bus.dsp_rob_idx = rob;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.rs_valid), 32'd0);
    endtask

    task automatic checkIssue(input string tag, input logic [ROB_IDX_W-1:0] rob,
                              input logic [31:0] v1, input logic [31:0] v2);
        checkOutput({tag, "_valid"}, 32'(bus.rs_valid), 32'd1);
        checkOutput({tag, "_rob"}, 32'(bus.rs_rob_idx), 32'(rob));
        checkOutput({tag, "_val1"}, bus.rs_val1, v1);
        checkOutput({tag, "_val2"}, bus.rs_val2, v2);
    endtask

    initial begin
        rst   = 1'b0;
        rdy   = 1'b1;
        flush = 1'b0;
        clearInputs();
        step();
        step();
        checkOutput("reset_valid", 32'(bus.rs_valid), 32'd0);
        checkOutput("reset_full", 32'(bus.rs_full), 32'd0);
        checkOutput("reset_rob", 32'(bus.rs_rob_idx), 32'd0);
        rst = 1'b1;
        step();

        // Ready op; a tag-0 broadcast during dispatch must not disturb the ready operand.
        applyStimulus(6'd1, 32'd5, 4'd0, 32'd7, 4'd0, 32'h11, 4'd3);
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'd0;
        bus.cdb_alu_val   = 32'hDEAD;
        step();
        clearInputs();
        checkIdle("ready_e0");
        step();
        checkIssue("ready", 4'd3, 32'd5, 32'd7);
        checkOutput("ready_opt", 32'(bus.rs_opt), 32'd1);
        checkOutput("ready_imm", bus.rs_imm, 32'h11);
        step();
        checkIdle("ready_after");

        // Wakeup from the ALU CDB two cycles after dispatch.
        applyStimulus(6'd2, 32'd0, 4'd6, 32'd1, 4'd0, 32'd0, 4'd2);
        step();
        clearInputs();
        step();
        checkIdle("wake_wait");
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'd6;
        bus.cdb_alu_val   = 32'h10;
        step();
        clearInputs();
        checkIdle("wake_edge");
        step();
        checkIssue("wake", 4'd2, 32'h10, 32'd1);
        step();
        checkIdle("wake_after");

        // Dispatch-time bypass from the LSB CDB.
        applyStimulus(6'd3, 32'd4, 4'd0, 32'd0, 4'd9, 32'd0, 4'd5);
        bus.cdb_lsb_valid = 1'b1;
        bus.cdb_lsb_src   = 4'd9;
        bus.cdb_lsb_val   = 32'hABCD;
        step();
        clearInputs();
        checkIdle("bypass_e0");
        step();
        checkIssue("bypass", 4'd5, 32'd4, 32'hABCD);
        step();

        // Both CDBs wake different operands of one entry in the same cycle.
        applyStimulus(6'd4, 32'd0, 4'd7, 32'd0, 4'd8, 32'd0, 4'd4);
        step();
        clearInputs();
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'd7;
        bus.cdb_alu_val   = 32'h77;
        bus.cdb_lsb_valid = 1'b1;
        bus.cdb_lsb_src   = 4'd8;
        bus.cdb_lsb_val   = 32'h88;
        step();
        clearInputs();
        step();
        checkIssue("dual", 4'd4, 32'h77, 32'h88);
        step();

        // Fill every entry behind tag 5, then try a ready ninth op.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(6'(k + 10), 32'd0, 4'd5, 32'(k), 4'd0, 32'(k), 4'(k + 1));
            step();
        end
        checkOutput("full_set", 32'(bus.rs_full), 32'd1);
        applyStimulus(6'd20, 32'h99, 4'd0, 32'h99, 4'd0, 32'd0, 4'd9);
        step();
        checkOutput("full_hold", 32'(bus.rs_full), 32'd1);
        checkIdle("full_ninth");
        clearInputs();
        step();
        checkIdle("full_no_ninth");
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'd5;
        bus.cdb_alu_val   = 32'h55;
        step();
        clearInputs();
        checkIdle("full_wake");
        for (int k = 0; k < 8; k++) begin
            step();
            checkIssue($sformatf("drain%0d", k), 4'(k + 1), 32'h55, 32'(k));
            if (k == 0) checkOutput("full_drop", 32'(bus.rs_full), 32'd0);
        end
        step();
        checkIdle("drain_done");

        // Flush discards waiting entries, a pending issue and a same-cycle dispatch.
        applyStimulus(6'd1, 32'd0, 4'hA, 32'd0, 4'd0, 32'd0, 4'd1);
        step();
        applyStimulus(6'd1, 32'd0, 4'hA, 32'd0, 4'd0, 32'd0, 4'd2);
        step();
        applyStimulus(6'd1, 32'd3, 4'd0, 32'd0, 4'd0, 32'd0, 4'd3);
        step();
        applyStimulus(6'd1, 32'd7, 4'd0, 32'd0, 4'd0, 32'd0, 4'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        clearInputs();
        checkIdle("flush_edge");
        checkOutput("flush_full", 32'(bus.rs_full), 32'd0);
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'hA;
        bus.cdb_alu_val   = 32'hAA;
        step();
        clearInputs();
        checkIdle("flush_p1");
        step();
        checkIdle("flush_p2");
        step();
        checkIdle("flush_p3");

        // Freeze with an op on the issue bus; dispatch and CDB are ignored meanwhile.
        applyStimulus(6'd5, 32'h66, 4'd0, 32'd0, 4'd0, 32'd0, 4'd6);
        step();
        clearInputs();
        step();
        checkIssue("freeze_pre", 4'd6, 32'h66, 32'd0);
        rdy = 1'b0;
        applyStimulus(6'd5, 32'h12, 4'd0, 32'd0, 4'd0, 32'd0, 4'd12);
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'd1;
        bus.cdb_alu_val   = 32'h1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkIssue($sformatf("frozen%0d", k), 4'd6, 32'h66, 32'd0);
        end
        clearInputs();
        rdy = 1'b1;
        checkOutput("release_valid", 32'(bus.rs_valid), 32'd1);
        step();
        checkIdle("release_after");
        step();
        checkIdle("release_nodsp");

        // Asynchronous reset mid-cycle with entries waiting and one op issued.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(6'd1, 32'd0, 4'hC, 32'd0, 4'd0, 32'd0, 4'(k + 1));
            step();
        end
        applyStimulus(6'd1, 32'd5, 4'd0, 32'd0, 4'd0, 32'd0, 4'd5);
        step();
        clearInputs();
        step();
        checkIssue("prereset", 4'd5, 32'd5, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("areset_valid", 32'(bus.rs_valid), 32'd0);
        checkOutput("areset_rob", 32'(bus.rs_rob_idx), 32'd0);
        checkOutput("areset_full", 32'(bus.rs_full), 32'd0);
        #2;
        rst = 1'b1;
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = 4'hC;
        bus.cdb_alu_val   = 32'hCC;
        step();
        clearInputs();
        step();
        checkIdle("postreset1");
        step();
        checkIdle("postreset2");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the integer ALU in the Tomasulo out-of-order core.
- Accepts decoded ALU/branch ops from dispatch and buffers them until both operands are ready.
- Snoops the ALU and LSB common data buses (CDB) for pending operand tags.
- Issues at most one ready op per cycle on the registered rs_* interface that the combinational ALU consumes.

Parameters:
- RS_SIZE, 8, number of entries; power of two, ≥2.
- ROB_IDX_W, 4, ROB tag width; tag 0 is reserved and means "no dependency" / "invalid".
- OPT_W, 6, internal op-code width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global ready; when low, the block freezes.
- flush  in  1  mispredict clear from the ROB.
- dsp_valid  in  1  dispatch request.
- dsp_opt  in  OPT_W  op code.
- dsp_val1, dsp_val2  in  32  operand values; meaningful only when the matching dep is 0.
- dsp_dep1, dsp_dep2  in  ROB_IDX_W  producer tags; 0 means the operand is ready.
- dsp_imm  in  32  immediate.
- dsp_rob_idx  in  ROB_IDX_W  destination tag; always nonzero.
- rs_full  out  1  no free entry.
- cdb_alu_valid, cdb_lsb_valid  in  1  CDB broadcast valid.
- cdb_alu_src, cdb_lsb_src  in  ROB_IDX_W  broadcast tag.
- cdb_alu_val, cdb_lsb_val  in  32  broadcast value.
- rs_valid  out  1  issue valid to the ALU.
- rs_opt  out  OPT_W  issued op code.
- rs_val1, rs_val2, rs_imm  out  32  issued operands.
- rs_rob_idx  out  ROB_IDX_W  issued destination tag.

Behaviour:
- Per-entry state: busy, opt, val1/dep1, val2/dep2, imm, rob_idx.
- Reset (rst=0, asynchronous): all entries not busy; all rs_* outputs 0; rs_full 0.
- rs_full is combinational from registered busy bits: 1 iff every entry is busy. It does not account for a same-cycle issue.
- Dispatch (rdy=1, flush=0, dsp_valid=1, rs_full=0):
  - Writes the lowest-index free entry at the clock edge.
  - dsp_valid while rs_full=1 is ignored; dispatch must hold the request.
- Dispatch-time bypass: if depX≠0 and a CDB broadcasts the same tag in that cycle, the entry stores the broadcast value with depX=0.
- Wakeup: each cycle, every busy entry with depX≠0 matching a valid CDB src captures the value and sets depX=0 at the edge.
  - Both CDBs may fire in the same cycle on different tags; each is matched independently.
  - Tag 0 never matches.
- Issue selection:
  - Combinational over registered state: lowest-index busy entry with dep1=0 and dep2=0.
  - At the edge, its fields are loaded into the rs_* registers, rs_valid=1, and the entry is freed.
  - With no ready entry, rs_valid=0 at the edge; the other rs_* outputs are don't-care but are driven to 0.
  - rs_valid is high for exactly one rdy-high cycle per issued op.
- Latency:
  - Op dispatched at edge E with both operands ready: rs_valid=1 after edge E+1.
  - Op woken by a CDB at edge E: rs_valid=1 after edge E+1.
  - No same-edge dispatch-to-issue.
- Simultaneous dispatch and issue in one cycle are allowed. The freed slot is reusable from the next cycle.
- Ordering: no age ordering; lowest index wins. Starvation is acceptable, because the ALU consumes one op every cycle.
- flush=1 (with rdy=1): at the edge, all entries are cleared and rs_valid=0. Same-cycle dispatch and issue are discarded. Flush dominates everything except reset.
- rdy=0: no state change. Entries, rs_* outputs and rs_full all hold; CDB and dispatch inputs are ignored.
- Reset mid-operation discards all entries immediately, independent of clk.

Test Plan:
- Ready op: dispatch ADD, val1=5, val2=7, deps 0, rob 3 → one cycle later rs_valid=1, rs_val1=5, rs_val2=7, rs_rob_idx=3; next cycle rs_valid=0.
- Wakeup: dispatch SUB with dep1=6, val2=1, rob 2; two cycles later cdb_alu_valid=1, src=6, val=0x10 → issue the following cycle with rs_val1=0x10, rs_val2=1.
- Bypass: dispatch with dep2=9 while cdb_lsb_valid=1, src=9, val=0xABCD → issue the next cycle with rs_val2=0xABCD.
- Full: dispatch 8 ops all with dep1=5 → rs_full=1 and a 9th request is ignored; broadcast tag 5 → all 8 issue on 8 consecutive cycles in index order 0..7; rs_full drops after the first issue.
- Flush/freeze: fill 3 entries, then flush=1 → rs_valid=0 and no issue afterwards even on a matching CDB. Hold rdy=0 with rs_valid=1 for 3 cycles → outputs frozen; releasing rdy gives one further valid cycle.
- Async reset: assert rst=0 mid-cycle with 4 busy entries → rs_valid and rs_full go to 0 immediately, with no issue after release.
